// File: rtl/booth_r4_seqmul.sv
// ---------------------------------------------------------------------------
// booth_r4_seqmul
//
// Sequential radix-4 Booth multiplier. It retires one Booth digit per cycle,
// LSB digit first, and handles unsigned and two's-complement operands.
//
// Parameters
//   WIDTH         operand width in bits (even, >= 4)
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   in_valid      operand set presented
//   in_ready      block can accept operands (state IDLE)
//   multiplicand  operand A, WIDTH bits
//   multiplier    operand B, WIDTH bits
//   sign          1 = both operands signed, 0 = both unsigned
//   out_valid     product available (state DONE)
//   out_ready     consumer accepts product
//   product       A*B, 2*WIDTH bits; meaningful only while out_valid=1
//   busy          high in CALC and DONE
//
// Optional feature
//   BOOTH_EARLY_TERM_EN  when defined, CALC stops as soon as every remaining
//                        Booth digit is zero. The product is unchanged.
// ---------------------------------------------------------------------------
module booth_r4_seqmul #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 sign,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    // Accumulator and shifted multiplicand width. The extra two bits keep the
    // running sum exact, so truncating it to 2*WIDTH bits is also exact.
    localparam int AW = 2 * WIDTH + 2;
    // Extended multiplier (WIDTH+2 bits) plus the implicit B[-1] = 0 below it.
    localparam int MW = WIDTH + 3;
    localparam int CW = $clog2(WIDTH / 2 + 1) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH / 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [AW-1:0]        mcand_q;    // A, sign/zero extended, pre-weighted by 4^i
    logic [MW-1:0]        mult_q;     // B triplet window; bits [2:0] are the current digit
    logic [AW-1:0]        acc_q;
    logic [CW-1:0]        cnt_q;      // index of the digit consumed next
    logic                 fin_q;      // last digit already accumulated
    logic [2*WIDTH-1:0]   product_q;

    logic [AW-1:0]        pp_s;
    logic                 neg_s;
    logic [AW-1:0]        acc_d;
    logic [AW-1:0]        mcand_d;
    logic [MW-1:0]        mult_d;
    logic [CW-1:0]        cnt_d;
    logic                 early_s;
    logic                 last_s;
    logic [AW-1:0]        a_ext_s;
    logic [MW-1:0]        b_ext_s;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == CALC) || (state_q == DONE);
    assign product   = product_q;

    // Operand extension at capture time; the sign mode is folded into the
    // extended operands, so it does not have to be stored separately.
    always_comb begin
        if (sign) begin
            a_ext_s = {{(AW - WIDTH){multiplicand[WIDTH-1]}}, multiplicand};
            b_ext_s = {{2{multiplier[WIDTH-1]}}, multiplier, 1'b0};
        end else begin
            a_ext_s = {{(AW - WIDTH){1'b0}}, multiplicand};
            b_ext_s = {2'b00, multiplier, 1'b0};
        end
    end

    // Booth digit decode and one accumulation step. A negative digit is the
    // inverted partial product plus a carry-in of 1 on the adder.
    always_comb begin
        pp_s  = {AW{1'b0}};
        neg_s = 1'b0;
        case (mult_q[2:0])
            3'b000, 3'b111: begin
                pp_s  = {AW{1'b0}};
                neg_s = 1'b0;
            end
            3'b001, 3'b010: begin
                pp_s  = mcand_q;
                neg_s = 1'b0;
            end
            3'b011: begin
                pp_s  = {mcand_q[AW-2:0], 1'b0};
                neg_s = 1'b0;
            end
            3'b100: begin
                pp_s  = ~{mcand_q[AW-2:0], 1'b0};
                neg_s = 1'b1;
            end
            3'b101, 3'b110: begin
                pp_s  = ~mcand_q;
                neg_s = 1'b1;
            end
            default: begin
                pp_s  = {AW{1'b0}};
                neg_s = 1'b0;
            end
        endcase

        acc_d   = acc_q + pp_s + {{(AW - 1){1'b0}}, neg_s};
        mcand_d = {mcand_q[AW-3:0], 2'b00};
        // Arithmetic shift: vacated bits copy the top extended bit, so they
        // can never make a remaining digit non-zero.
        mult_d  = {{2{mult_q[MW-1]}}, mult_q[MW-1:2]};
        cnt_d   = cnt_q + CNT_ONE;
    end

    // Early-exit detection: the current digit is the last non-zero one when
    // every unconsumed multiplier bit equals the top bit of this triplet.
`ifdef BOOTH_EARLY_TERM_EN
    assign early_s = (mult_q[MW-1:3] == {(MW - 3){mult_q[2]}});
`else
    assign early_s = 1'b0;
`endif

    assign last_s = (cnt_q == CNT_LAST) || early_s;

    // Control FSM and datapath registers. The cycle after the last digit copies
    // the accumulator into the product register and enters DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= {AW{1'b0}};
            mult_q    <= {MW{1'b0}};
            acc_q     <= {AW{1'b0}};
            cnt_q     <= {CW{1'b0}};
            fin_q     <= 1'b0;
            product_q <= {(2 * WIDTH){1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mcand_q <= a_ext_s;
                        mult_q  <= b_ext_s;
                        acc_q   <= {AW{1'b0}};
                        cnt_q   <= {CW{1'b0}};
                        fin_q   <= 1'b0;
                        state_q <= CALC;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    if (fin_q) begin
                        product_q <= acc_q[2*WIDTH-1:0];
                        state_q   <= DONE;
                    end else begin
                        acc_q   <= acc_d;
                        mcand_q <= mcand_d;
                        mult_q  <= mult_d;
                        cnt_q   <= cnt_d;
                        fin_q   <= last_s;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_r4_seqmul.sv
// ---------------------------------------------------------------------------
// tb_booth_r4_seqmul
//
// Directed vectors and corner sequences on an 8-bit and a 32-bit instance,
// plus random-operand regressions on WIDTH = 4, 8 and 32 instances with
// random handshake gaps, checked against a behavioural multiply.
// ---------------------------------------------------------------------------
module tb_booth_r4_seqmul;

    localparam int NRAND = 400;

`ifdef BOOTH_EARLY_TERM_EN
    localparam int LAT32_EARLY = 2;
`else
    localparam int LAT32_EARLY = 18;
`endif

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   rand_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string nm,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- 8-bit directed instance ----------------
    logic        iv8, ir8, s8, ov8, or8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    booth_r4_seqmul #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .multiplicand(a8), .multiplier(b8), .sign(s8),
        .out_valid(ov8), .out_ready(or8), .product(p8), .busy(busy8)
    );

    // ---------------- 32-bit directed instance ----------------
    logic        iv32, ir32, s32, ov32, or32, busy32;
    logic [31:0] a32, b32;
    logic [63:0] p32;

    booth_r4_seqmul #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
        .multiplicand(a32), .multiplier(b32), .sign(s32),
        .out_valid(ov32), .out_ready(or32), .product(p32), .busy(busy32)
    );

    // Present one operand set, scramble inputs after acceptance, and count
    // edges from acceptance until out_valid is seen.
    task automatic op8(input logic sg, input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] prod, output int lat);
        int t;
        @(negedge clk);
        iv8 = 1'b1; a8 = a; b8 = b; s8 = sg;
        t = 0;
        while (!ir8 && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A; s8 = ~sg;
        lat = 0;
        while (!ov8 && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        prod = p8;
    endtask

    task automatic rel8();
        or8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or8 = 1'b0;
    endtask

    task automatic op32(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] prod, output int lat);
        int t;
        @(negedge clk);
        iv32 = 1'b1; a32 = a; b32 = b; s32 = sg;
        t = 0;
        while (!ir32 && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        @(negedge clk);
        iv32 = 1'b0; a32 = 32'hDEADBEEF; b32 = 32'h0BADF00D; s32 = ~sg;
        lat = 0;
        while (!ov32 && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        prod = p32;
        or32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or32 = 1'b0;
    endtask

    typedef struct {
        logic        sg;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    // ---------------- directed sequence ----------------
    initial begin
        vec_t        vt [12];
        logic [15:0] prod;
        logic [63:0] prod32;
        int          lat;
        bit          bad;
        int          t;

        errors = 0; checks = 0;
        vt[0]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vt[1]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
        vt[2]  = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
        vt[3]  = '{1'b0, 8'h03, 8'h05, 16'h000F};
        vt[4]  = '{1'b1, 8'h7F, 8'h80, 16'hC080};
        vt[5]  = '{1'b0, 8'h00, 8'hAB, 16'h0000};
        vt[6]  = '{1'b1, 8'h80, 8'h7F, 16'hC080};
        vt[7]  = '{1'b0, 8'h80, 8'h80, 16'h4000};
        vt[8]  = '{1'b1, 8'hFE, 8'hFD, 16'h0006};
        vt[9]  = '{1'b0, 8'hFF, 8'h01, 16'h00FF};
        vt[10] = '{1'b1, 8'h01, 8'h80, 16'hFF80};
        vt[11] = '{1'b0, 8'h0F, 8'h11, 16'h00FF};

        rst = 1'b1;
        iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00; s8 = 1'b0; or8 = 1'b0;
        iv32 = 1'b0; a32 = 32'h0; b32 = 32'h0; s32 = 1'b0; or32 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(ir8 == 1'b1, "reset in_ready", 64'(ir8), 64'h1);
        chk(ov8 == 1'b0, "reset out_valid", 64'(ov8), 64'h0);
        chk(busy8 == 1'b0, "reset busy", 64'(busy8), 64'h0);
        chk(p8 == 16'h0000, "reset product", 64'(p8), 64'h0);
        rst = 1'b0;

        // Table of 8-bit vectors
        for (int i = 0; i < 12; i++) begin
            op8(vt[i].sg, vt[i].a, vt[i].b, prod, lat);
            chk(prod == vt[i].exp, $sformatf("vec%0d product", i), 64'(prod), 64'(vt[i].exp));
`ifdef BOOTH_EARLY_TERM_EN
            chk(lat >= 2 && lat <= 6, $sformatf("vec%0d latency", i), 64'(lat), 64'd6);
`else
            chk(lat == 6, $sformatf("vec%0d latency", i), 64'(lat), 64'd6);
`endif
            rel8();
            chk(ir8 && !ov8 && !busy8 && p8 == vt[i].exp, $sformatf("vec%0d idle hold", i),
                64'({ir8, ov8, busy8, p8}), 64'({3'b100, vt[i].exp}));
        end

        // Consumer stall for 10 cycles with new operands presented meanwhile
        op8(1'b0, 8'h12, 8'h34, prod, lat);
        chk(prod == 16'h03A8, "stall product", 64'(prod), 64'h03A8);
        for (int k = 0; k < 10; k++) begin
            iv8 = 1'b1; a8 = 8'h77; b8 = 8'h11; s8 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk(ov8 && !ir8 && busy8 && p8 == 16'h03A8, $sformatf("stall hold %0d", k),
                64'({ov8, ir8, busy8, p8}), 64'({3'b101, 16'h03A8}));
        end
        or8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk(ir8 && !ov8 && !busy8, "release no bypass",
            64'({ir8, ov8, busy8}), 64'({3'b100}));
        iv8 = 1'b0; or8 = 1'b0;

        // Reset asserted during the third CALC cycle
        @(negedge clk);
        iv8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk(ir8 && !ov8 && !busy8 && p8 == 16'h0000, "abort reset state",
            64'({ir8, ov8, busy8, p8}), 64'({3'b100, 16'h0000}));
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ov8) bad = 1'b1;
        end
        chk(!bad, "abort no output", 64'(bad), 64'h0);
        op8(1'b0, 8'h03, 8'h05, prod, lat);
        chk(prod == 16'h000F, "after abort product", 64'(prod), 64'h000F);
        rel8();

        // 32-bit directed cases
        op32(1'b0, 32'h12345678, 32'h00000001, prod32, lat);
        chk(prod32 == 64'h0000000012345678, "w32 A*1 product", prod32, 64'h0000000012345678);
        chk(lat == LAT32_EARLY, "w32 A*1 latency", 64'(lat), 64'(LAT32_EARLY));
        op32(1'b1, 32'h12345678, 32'hFFFFFFFF, prod32, lat);
        chk(prod32 == 64'hFFFFFFFFEDCBA988, "w32 A*-1 product", prod32, 64'hFFFFFFFFEDCBA988);
        chk(lat == LAT32_EARLY, "w32 A*-1 latency", 64'(lat), 64'(LAT32_EARLY));
        op32(1'b1, 32'h80000000, 32'h80000000, prod32, lat);
        chk(prod32 == 64'h4000000000000000, "w32 min*min", prod32, 64'h4000000000000000);
        op32(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, prod32, lat);
        chk(prod32 == 64'hFFFFFFFE00000001, "w32 max*max", prod32, 64'hFFFFFFFE00000001);

        t = 0;
        while (rand_done < 3 && t < 60000) begin
            @(posedge clk);
            t++;
        end
        chk(rand_done == 3, "random regressions finished", 64'(rand_done), 64'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- random regressions ----------------
    initial rand_done = 0;

    for (genvar g = 0; g < 3; g++) begin : g_rand
        localparam int W = (g == 0) ? 4 : ((g == 1) ? 8 : 32);

        logic           rrst, iv, ir, s, ov, ordy, bz;
        logic [W-1:0]   a, b;
        logic [2*W-1:0] p;

        booth_r4_seqmul #(.WIDTH(W)) u (
            .clk(clk), .rst(rrst), .in_valid(iv), .in_ready(ir),
            .multiplicand(a), .multiplier(b), .sign(s),
            .out_valid(ov), .out_ready(ordy), .product(p), .busy(bz)
        );

        initial begin
            logic [W-1:0]   ra, rb;
            logic           rs;
            logic [2*W-1:0] ex;
            logic [W-1:0]   ones;
            logic [W-1:0]   minneg;
            int             t;
            bit             got;

            ones   = '1;
            minneg = '0;
            minneg[W-1] = 1'b1;
            rrst = 1'b1; iv = 1'b0; a = '0; b = '0; s = 1'b0; ordy = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            rrst = 1'b0;
            for (int n = 0; n < NRAND; n++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                case ($urandom_range(0, 7))
                    0:       ra = ones;
                    1:       ra = minneg;
                    default: ra = W'($urandom());
                endcase
                case ($urandom_range(0, 7))
                    0:       rb = ones;
                    1:       rb = minneg;
                    default: rb = W'($urandom());
                endcase
                rs = 1'($urandom_range(0, 1));
                if (rs) begin
                    ex = $signed({{W{ra[W-1]}}, ra}) * $signed({{W{rb[W-1]}}, rb});
                end else begin
                    ex = {{W{1'b0}}, ra} * {{W{1'b0}}, rb};
                end
                iv = 1'b1; a = ra; b = rb; s = rs;
                t = 0;
                while (!ir && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                @(posedge clk);
                @(negedge clk);
                iv = 1'b0; a = W'($urandom()); b = W'($urandom()); s = 1'($urandom_range(0, 1));
                got = 1'b0;
                t = 0;
                while (!got && t < 200) begin
                    if (ov) begin
                        ordy = 1'($urandom_range(0, 1));
                        if (ordy) begin
                            chk(p == ex, $sformatf("rand w%0d op%0d", W, n), 64'(p), 64'(ex));
                            got = 1'b1;
                        end
                    end else begin
                        ordy = 1'b0;
                    end
                    @(posedge clk);
                    @(negedge clk);
                    t++;
                end
                ordy = 1'b0;
                if (!got) begin
                    chk(1'b0, $sformatf("rand w%0d op%0d timeout", W, n), 64'(t), 64'd200);
                end
            end
            rand_done++;
        end
    end

endmodule
